// File: rtl/cic_integrator_mc.sv
// Multichannel CIC integrator cascade with run-time active stage count and fixed N_STG latency.
// Optional per-channel accumulator clear port enabled by defining CIC_INT_CHCLR_EN.
module cic_integrator_mc #(
  parameter int IN_W    = 16,
  parameter int ACC_W   = 37,
  parameter int N_STG   = 8,
  parameter int N_CH    = 16,
  parameter int CH_W    = 4,
  parameter int CFG_W   = 16,
  parameter int DEF_STG = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_done,
  output logic             busy,
  input  logic [IN_W-1:0]  din,
  input  logic             din_valid,
  input  logic [CH_W-1:0]  din_ch,
`ifdef CIC_INT_CHCLR_EN
  input  logic             ch_clr,
  input  logic [CH_W-1:0]  ch_clr_idx,
`endif
  output logic [ACC_W-1:0] dout,
  output logic             dout_valid,
  output logic [CH_W-1:0]  dout_ch
);

  localparam int CNT_W = (N_STG > 1) ? $clog2(N_STG) : 1;
  localparam int K_W   = $clog2(N_STG + 1);
  localparam int CH_N  = 2 ** CH_W;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   drain_cnt;
  logic [CFG_W-1:0]   cfg_lat;
  logic [K_W-1:0]     k_act;
  logic               accept;
  logic               clr_hit;

  // Index 0 is the input register; index k+1 holds the output of stage k+1.
  logic               v_q  [N_STG+1];
  logic [CH_W-1:0]    ch_q [N_STG+1];
  logic [ACC_W-1:0]   d_q  [N_STG+1];
  logic [ACC_W-1:0]   stg_out [N_STG];
  logic               stg_on  [N_STG];
  logic [ACC_W-1:0]   acc [N_STG][CH_N];

  assign accept = (state == RUN) && din_valid && (32'(din_ch) < N_CH);
`ifdef CIC_INT_CHCLR_EN
  assign clr_hit = (state == RUN) && ch_clr;
`else
  assign clr_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_valid) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == CNT_W'(N_STG - 1)) state_nxt = CLEAR;
      CLEAR:   state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= '0;
      cfg_lat   <= '0;
      k_act     <= K_W'(DEF_STG);
    end else begin
      state <= state_nxt;
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
      if (state == RUN && cfg_valid) cfg_lat <= cfg_data;
      if (state == CLEAR) begin
        if (cfg_lat == '0)                  k_act <= K_W'(1);
        else if (cfg_lat > CFG_W'(N_STG))   k_act <= K_W'(N_STG);
        else                                k_act <= K_W'(cfg_lat);
      end
    end
  end

  assign busy     = (state != RUN);
  assign cfg_done = (state == DONE);

  always_comb begin
    for (int unsigned k = 0; k < N_STG; k++) begin
      stg_on[k]  = (k + 1 <= 32'(k_act));
      stg_out[k] = d_q[k];
      if (stg_on[k]) begin
        stg_out[k] = acc[k][ch_q[k]] + d_q[k];
`ifdef CIC_INT_CHCLR_EN
        // A same-edge channel clear turns the update into a plain load.
        if (clr_hit && ch_q[k] == ch_clr_idx) stg_out[k] = d_q[k];
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 0; k <= N_STG; k++) begin
        v_q[k]  <= 1'b0;
        ch_q[k] <= '0;
        d_q[k]  <= '0;
      end
    end else begin
      v_q[0] <= accept;
      if (accept) begin
        ch_q[0] <= din_ch;
        d_q[0]  <= ACC_W'(signed'(din));
      end
      for (int unsigned k = 0; k < N_STG; k++) begin
        v_q[k+1]  <= v_q[k];
        ch_q[k+1] <= ch_q[k];
        d_q[k+1]  <= stg_out[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 0; k < N_STG; k++)
        for (int unsigned c = 0; c < CH_N; c++)
          acc[k][c] <= '0;
    end else if (state == CLEAR) begin
      for (int unsigned k = 0; k < N_STG; k++)
        for (int unsigned c = 0; c < CH_N; c++)
          acc[k][c] <= '0;
    end else begin
`ifdef CIC_INT_CHCLR_EN
      if (clr_hit)
        for (int unsigned k = 0; k < N_STG; k++)
          acc[k][ch_clr_idx] <= '0;
`endif
      for (int unsigned k = 0; k < N_STG; k++)
        if (v_q[k] && stg_on[k]) acc[k][ch_q[k]] <= stg_out[k];
    end
  end

  assign dout       = d_q[N_STG];
  assign dout_valid = v_q[N_STG];
  assign dout_ch    = ch_q[N_STG];

endmodule

// File: tb/tb_cic_integrator_mc.sv
// Randomized and directed bench for cic_integrator_mc against a per-channel cascaded-sum model.
module tb_cic_integrator_mc;
  localparam int IN_W    = 16;
  localparam int ACC_W   = 18;
  localparam int N_STG   = 8;
  localparam int N_CH    = 12;
  localparam int CH_W    = 4;
  localparam int CFG_W   = 16;
  localparam int DEF_STG = 5;
  localparam longint MASK = (longint'(1) << ACC_W) - 1;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CFG_W-1:0] cfg_data = '0;
  logic             cfg_done;
  logic             busy;
  logic [IN_W-1:0]  din = '0;
  logic             din_valid = 1'b0;
  logic [CH_W-1:0]  din_ch = '0;
  logic             ch_clr = 1'b0;
  logic [CH_W-1:0]  ch_clr_idx = '0;
  logic [ACC_W-1:0] dout;
  logic             dout_valid;
  logic [CH_W-1:0]  dout_ch;

  cic_integrator_mc #(
    .IN_W(IN_W), .ACC_W(ACC_W), .N_STG(N_STG), .N_CH(N_CH),
    .CH_W(CH_W), .CFG_W(CFG_W), .DEF_STG(DEF_STG)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_done(cfg_done), .busy(busy),
    .din(din), .din_valid(din_valid), .din_ch(din_ch),
`ifdef CIC_INT_CHCLR_EN
    .ch_clr(ch_clr), .ch_clr_idx(ch_clr_idx),
`endif
    .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch)
  );

  always #5 CLK = ~CLK;

  typedef struct { longint t; int ch; longint val; } exp_t;
  exp_t   exp_q[$];
  longint m_acc [N_STG][16];
  int     m_k = DEF_STG;
  int     busy_left = 0;
  longint lat = 0;
  longint cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;

  task automatic check(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, want);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < N_STG; k++)
      for (int c = 0; c < 16; c++) m_acc[k][c] = 0;
  endfunction

  // Active stages form a chain of running sums; bypassed stages pass the value on.
  function automatic longint model_push(input int ch, input longint x);
    longint v = x & MASK;
    for (int k = 0; k < m_k; k++) begin
      m_acc[k][ch] = (m_acc[k][ch] + v) & MASK;
      v = m_acc[k][ch];
    end
    return v;
  endfunction

  task automatic tick();
    bit acc_ok, cfg_take, clr_take;
    exp_t e;
    acc_ok   = (busy_left == 0) && din_valid && (int'(din_ch) < N_CH);
    cfg_take = (busy_left == 0) && cfg_valid;
    clr_take = (busy_left == 0) && ch_clr;
    @(posedge CLK);
    cyc++;
    if (clr_take)
      for (int k = 0; k < N_STG; k++) m_acc[k][ch_clr_idx] = 0;
    if (acc_ok) begin
      e.t = cyc + N_STG;
      e.ch = int'(din_ch);
      e.val = model_push(int'(din_ch), longint'($signed(din)));
      exp_q.push_back(e);
    end
    if (cfg_take) begin
      busy_left = N_STG + 2;
      lat = longint'(cfg_data);
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 1) begin
        model_clear();
        m_k = (lat < 1) ? 1 : (lat > N_STG) ? N_STG : int'(lat);
      end
    end
    #1;
    check("busy", longint'(busy), longint'(busy_left != 0));
    check("cfg_done", longint'(cfg_done), longint'(busy_left == 1));
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      check("dout_valid", longint'(dout_valid), 1);
      check("dout_ch", longint'(dout_ch), exp_q[0].ch);
      check("dout", longint'(dout), exp_q[0].val);
      void'(exp_q.pop_front());
    end else begin
      check("dout_valid_idle", longint'(dout_valid), 0);
    end
  endtask

  task automatic send(input int ch, input int val);
    din_valid = 1'b1;
    din_ch = CH_W'(ch);
    din = IN_W'(val);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic reconfig(input int k, input bit poke_din);
    cfg_valid = 1'b1;
    cfg_data = CFG_W'(k);
    tick();
    cfg_valid = 1'b0;
    din_valid = poke_din;
    din_ch = 4'd1;
    din = 16'd7;
    while (busy_left > 0) tick();
    din_valid = 1'b0;
  endtask

  task automatic impulse(input int ch, input int zeros);
    send(ch, 1);
    repeat (zeros) send(ch, 0);
    idle(N_STG + 1);
  endtask

  initial begin
    model_clear();
    #12;
    check("rst_dout", longint'(dout), 0);
    check("rst_dout_valid", longint'(dout_valid), 0);
    check("rst_dout_ch", longint'(dout_ch), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_cfg_done", longint'(cfg_done), 0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // DEF_STG cascade, steady input
    repeat (8) send(0, 1);
    idle(N_STG + 1);

    // K=1 impulse with din poked during drain, then K=2
    reconfig(1, 1'b1);
    impulse(3, 5);
    reconfig(2, 1'b0);
    impulse(3, 5);

    // interleaved channels
    reconfig(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(0, 1);
      send(1, -2);
    end
    idle(N_STG + 1);

    // wrap-around at ACC_W=18
    repeat (5) send(5, 32767);
    idle(N_STG + 1);

    // clamp boundaries
    reconfig(0, 1'b0);
    impulse(4, 4);
    reconfig(40, 1'b1);
    impulse(4, 8);

    // out-of-range channel is dropped
    send(13, 9);
    send(15, 9);
    idle(N_STG + 1);

`ifdef CIC_INT_CHCLR_EN
    reconfig(1, 1'b0);
    repeat (5) send(2, 1);
    idle(N_STG + 1);
    ch_clr = 1'b1;
    ch_clr_idx = 4'd2;
    send(2, 1);
    ch_clr = 1'b0;
    send(2, 1);
    idle(N_STG + 1);
`endif

    // randomized traffic with occasional reconfiguration
    for (int i = 0; i < 600; i++) begin
      din_valid = ($urandom_range(0, 3) != 0);
      din_ch = CH_W'($urandom_range(0, 15));
      din = IN_W'($urandom);
      cfg_valid = ($urandom_range(0, 79) == 0);
      cfg_data = CFG_W'($urandom_range(0, 20));
      tick();
    end
    din_valid = 1'b0;
    cfg_valid = 1'b0;
    idle(2 * N_STG + 4);

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) send(i % 3, i + 1);
    #2 nRST = 1'b0;
    #1;
    exp_q.delete();
    model_clear();
    m_k = DEF_STG;
    busy_left = 0;
    check("midrst_dout_valid", longint'(dout_valid), 0);
    check("midrst_dout", longint'(dout), 0);
    nRST = 1'b1;
    idle(N_STG);
    repeat (4) send(6, 3);
    idle(N_STG + 1);
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cic_integrator_mc.md
# cic_integrator_mc

Multichannel, fully synchronous CIC integrator cascade for the DDC decimation path. It sits between the NCO mixer output and the CIC decimator/comb section. Channels arrive time-interleaved on one stream, each tagged with a channel index. Every channel keeps its own accumulator at every stage. The number of active stages is set at run time, and the cascade has a fixed pipeline latency.

## Interface
- IN_W, 16: input sample width, signed.
- ACC_W, 37: accumulator/output width, signed; ACC_W ≥ IN_W.
- N_STG, 8: compiled stage count (maximum active stages), 1..16.
- N_CH, 16: channel count, 1..16.
- CH_W, 4: channel index width; 2^CH_W ≥ N_CH.
- CFG_W, 16: configuration word width.
- DEF_STG, 5: active stage count after reset, 1..N_STG.
- CLK  in  1  clock; every register in the block is clocked on its rising edge.
- nRST  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  request to reconfigure; sampled only in RUN.
- cfg_data  in  CFG_W  requested active stage count K.
- cfg_done  out  1  one-cycle pulse when the new configuration is in effect.
- busy  out  1  high outside RUN; din is dropped while busy.
- din  in  IN_W  input sample.
- din_valid  in  1  din/din_ch qualifier, one sample per cycle max.
- din_ch  in  CH_W  channel of din; values ≥ N_CH are dropped.
- dout  out  ACC_W  integrator output.
- dout_valid  out  1  dout/dout_ch qualifier.
- dout_ch  out  CH_W  channel of dout.

## Operation
- Stage input: din is sign-extended to ACC_W.
- Stage k (1..N_STG) is one pipeline register. When stage k's input is valid for channel c:
  - If k ≤ K: acc[k][c] <= acc[k][c] + x, and the updated sum is passed on.
  - If k > K: the stage is a bypass. x is passed on unchanged and acc[k][c] is not written.
- Each stage does its read-modify-write for its own channel in a single cycle. Back-to-back samples of the same channel therefore have no hazard.
- Arithmetic is two's-complement modulo 2^ACC_W. Wrap-around is required behaviour (CIC correctness). There is no saturation.
- The valid bit and channel tag travel through the stages with the data.
- FSM states:
  - RUN: normal operation. cfg_valid=1 → DRAIN, and cfg_data is latched.
  - DRAIN: lasts N_STG cycles. din is ignored. Samples already in flight finish with the old K and are emitted normally. Then → CLEAR.
  - CLEAR: 1 cycle. Every acc[k][c] is set to 0. K is loaded with clamp(latched cfg_data, 1, N_STG). Then → DONE.
  - DONE: 1 cycle. cfg_done=1. Then → RUN.
- cfg_valid is ignored in DRAIN, CLEAR and DONE.
- busy = (state ≠ RUN).

## Timing
- Reset values:
  - state=RUN, K=DEF_STG.
  - All accumulators and pipeline registers are 0.
  - dout=0, dout_valid=0, dout_ch=0, cfg_done=0, busy=0.
- Latency: a sample accepted at edge t appears on dout at edge t+N_STG. The latency does not depend on K.
- Throughput: one sample per cycle. Any interleaving of channels is allowed, including repeats of the same channel.
- Reconfiguration: from cfg_valid sampled at edge t:
  - busy=1 from t to t+N_STG+1.
  - cfg_done=1 in cycle t+N_STG+2.
  - The first new sample is accepted at t+N_STG+2.
- din_valid while busy: the sample is dropped and never appears on the output.
- Asserting nRST mid-operation clears everything immediately. In-flight samples are lost and no dout_valid is produced for them.

## Configuration
- CIC_INT_CHCLR_EN defined:
  - Adds the input ports ch_clr (1 bit) and ch_clr_idx (CH_W bits).
  - ch_clr=1 in RUN zeroes acc[1..N_STG][ch_clr_idx] at that edge.
  - Any stage that updates the same channel at the same edge uses clear-then-add, i.e. acc = x.
  - ch_clr is ignored outside RUN.
- Macro undefined: the ports do not exist. Accumulators are cleared only by reset and reconfiguration.

## Test plan
- Reset with DEF_STG=5, then din=1 on ch 0 for 8 cycles → busy=0, and dout_valid rises 8 cycles after the first sample.
- Reconfigure cfg_data=1. Then send an impulse din=1 followed by zeros on ch 3 → dout_ch=3 with dout 1,1,1,…
  - Repeat with cfg_data=2 → dout 1,2,3,4.
- Interleave ch 0 (din=1) and ch 1 (din=−2) with K=1 → ch 0 outputs 1,2,3 and ch 1 outputs −2,−4,−6, uncorrupted.
- Wrap-around with ACC_W=18, IN_W=16, K=1: din=32767 five times → 32767, 65534, 98301, 131068, −98309.
- Boundary cases:
  - cfg_data=0 → K=1. cfg_data=40 → K=N_STG.
  - din_valid during DRAIN is dropped.
  - cfg_done pulses exactly at cycle N_STG+2.
- With CIC_INT_CHCLR_EN, K=1: after ch 2 reaches 5, pulse ch_clr on ch 2 while din=1 on ch 2 → the next output for ch 2 is 1.
  - Reset mid-stream → dout_valid stays 0 for the next N_STG cycles.
